// File: rtl/ctrl_pipeline.sv
// RV32I control decode plus EX/MEM/WB control-signal delay stages with redirect flush.
// Optional load-use interlock is enabled by defining CTRL_PIPELINE_HAZARD_EN.
module ctrl_pipeline #(
    parameter int unsigned MEM_DEPTH   = 2,
    parameter int unsigned WB_DEPTH    = 3,
    parameter int unsigned FLUSH_SLOTS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        stall,
    input  logic        br_taken,
    output logic [4:0]  imm_sel,
    output logic        mux_a,
    output logic        mux_b,
    output logic        alu_unsigned,
    output logic        br_unsigned,
    output logic        pc_sel,
    output logic        mem_we,
    output logic        load_en,
    output logic [1:0]  wb_sel,
    output logic        reg_we,
    output logic        illegal,
    output logic        hazard_stall
);

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_U, FMT_SB, FMT_UJ
    } fmt_e;

    typedef struct packed {
        logic [4:0] imm_sel;
        logic       mux_a;
        logic       mux_b;
        logic       alu_unsigned;
        logic       br_unsigned;
        logic       is_branch;
        logic       is_jump;
        logic       mem_we;
        logic       load_en;
        logic [1:0] wb_sel;
        logic       reg_we;
        logic       illegal;
        logic [4:0] rd;
    } ctrl_t;

    fmt_e       fmt;
    ctrl_t      dec;
    ctrl_t      ex;
    ctrl_t      ex_next;
    logic [3:0] mem_pipe [2:MEM_DEPTH];
    logic       wb_pipe  [2:WB_DEPTH];
    logic [1:0] flush_cnt;
    logic       pc_sel_q;
    logic       redirect;
    logic       accept;
    logic       unused_bits;

    always_comb begin
        dec = '0;
        fmt = FMT_NONE;
        case (instr[6:0])
            7'b0000011: begin fmt = FMT_I; dec.load_en = 1'b1; dec.wb_sel = 2'b01; end
            7'b0010011: begin
                fmt = FMT_I;
                dec.alu_unsigned = (instr[14:12] == 3'b011) || (instr[14:12] == 3'b101 && !instr[30]);
            end
            7'b1100111: begin fmt = FMT_I; dec.is_jump = 1'b1; dec.wb_sel = 2'b10; end
            7'b0100011: begin fmt = FMT_S; dec.mem_we = 1'b1; end
            7'b0110111: begin fmt = FMT_U; dec.wb_sel = 2'b11; end
            7'b0010111: begin fmt = FMT_U; dec.mux_a = 1'b1; end
            7'b1100011: begin
                fmt = FMT_SB;
                dec.mux_a       = 1'b1;
                dec.is_branch   = 1'b1;
                dec.br_unsigned = instr[13];
            end
            7'b1101111: begin fmt = FMT_UJ; dec.mux_a = 1'b1; dec.is_jump = 1'b1; dec.wb_sel = 2'b10; end
            7'b0110011: begin
                fmt = FMT_R;
                dec.alu_unsigned = (instr[14:12] == 3'b011) || (instr[14:12] == 3'b101 && !instr[30]);
            end
            default: dec.illegal = 1'b1;
        endcase
        case (fmt)
            FMT_I:   dec.imm_sel = 5'b00001;
            FMT_S:   dec.imm_sel = 5'b00010;
            FMT_U:   dec.imm_sel = 5'b00100;
            FMT_SB:  dec.imm_sel = 5'b01000;
            FMT_UJ:  dec.imm_sel = 5'b10000;
            default: dec.imm_sel = 5'b00000;
        endcase
        if (fmt != FMT_NONE) begin
            dec.mux_b  = (fmt != FMT_R);
            dec.reg_we = (fmt != FMT_S) && (fmt != FMT_SB);
            dec.rd     = instr[11:7];
        end
    end

`ifdef CTRL_PIPELINE_HAZARD_EN
    logic rs1_use;
    logic rs2_use;
    logic hz;
    always_comb begin
        rs1_use = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_SB);
        rs2_use = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_SB);
        hz = instr_valid && ex.load_en && (ex.rd != 5'd0) && (flush_cnt == 2'd0) &&
             ((rs1_use && instr[19:15] == ex.rd) || (rs2_use && instr[24:20] == ex.rd));
    end
    assign hazard_stall = hz & ~stall;
`else
    assign hazard_stall = 1'b0;
`endif

    assign instr_ready = rst_n & ~stall & ~hazard_stall;
    assign accept      = instr_valid & instr_ready;
    assign redirect    = (ex.is_branch & br_taken) | ex.is_jump;
    assign unused_bits = ^{instr[31], instr[29:15], ex.rd};

    // Instructions arriving while the flush counter runs are consumed but enter as bubbles.
    always_comb begin
        ex_next = '0;
        if (accept && flush_cnt == 2'd0)
            ex_next = dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex        <= '0;
            flush_cnt <= '0;
            pc_sel_q  <= 1'b0;
            for (int unsigned i = 2; i <= MEM_DEPTH; i++) mem_pipe[i] <= '0;
            for (int unsigned i = 2; i <= WB_DEPTH; i++)  wb_pipe[i]  <= 1'b0;
        end else if (!stall) begin
            ex          <= ex_next;
            pc_sel_q    <= redirect;
            mem_pipe[2] <= {ex.mem_we, ex.load_en, ex.wb_sel};
            for (int unsigned i = 3; i <= MEM_DEPTH; i++) mem_pipe[i] <= mem_pipe[i-1];
            wb_pipe[2]  <= ex.reg_we;
            for (int unsigned i = 3; i <= WB_DEPTH; i++)  wb_pipe[i]  <= wb_pipe[i-1];
            if (redirect)
                flush_cnt <= 2'(FLUSH_SLOTS);
            else if (flush_cnt != 2'd0)
                flush_cnt <= flush_cnt - 2'd1;
        end
    end

    assign imm_sel      = ex.imm_sel;
    assign mux_a        = ex.mux_a;
    assign mux_b        = ex.mux_b;
    assign alu_unsigned = ex.alu_unsigned;
    assign br_unsigned  = ex.br_unsigned;
    assign illegal      = ex.illegal;
    assign pc_sel       = pc_sel_q;
    assign mem_we       = mem_pipe[MEM_DEPTH][3];
    assign load_en      = mem_pipe[MEM_DEPTH][2];
    assign wb_sel       = mem_pipe[MEM_DEPTH][1:0];
    assign reg_we       = wb_pipe[WB_DEPTH];

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed self-checking bench for ctrl_pipeline at default parameters (MEM 2, WB 3, FLUSH 1).
module tb_ctrl_pipeline;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        br_taken;
    logic [4:0]  imm_sel;
    logic        mux_a, mux_b, alu_unsigned, br_unsigned, pc_sel;
    logic        mem_we, load_en, reg_we, illegal, hazard_stall;
    logic [1:0]  wb_sel;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SW   = 32'h0020A023;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] ADDI = 32'h00100213;
    localparam logic [31:0] LW   = 32'h0000A283;
    localparam logic [31:0] ADD6 = 32'h00528333;
    localparam logic [31:0] BAD  = 32'h0000007F;

    ctrl_pipeline #(.MEM_DEPTH(2), .WB_DEPTH(3), .FLUSH_SLOTS(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .stall(stall), .br_taken(br_taken),
        .imm_sel(imm_sel), .mux_a(mux_a), .mux_b(mux_b), .alu_unsigned(alu_unsigned),
        .br_unsigned(br_unsigned), .pc_sel(pc_sel), .mem_we(mem_we), .load_en(load_en),
        .wb_sel(wb_sel), .reg_we(reg_we), .illegal(illegal), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; stall = 1'b0; br_taken = 1'b0;
        #12;
        checks++; if ({imm_sel, mux_a, mux_b, alu_unsigned, br_unsigned, pc_sel, mem_we, load_en, wb_sel, reg_we, illegal, hazard_stall} !== 16'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {imm_sel, mux_a, mux_b, alu_unsigned, br_unsigned, pc_sel, mem_we, load_en, wb_sel, reg_we, illegal, hazard_stall}); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", instr_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", instr_ready); end
        step();
    endtask

    task automatic test_add();
        instr = ADD; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++; if ({mux_a, mux_b, imm_sel} !== 7'b0) begin errors++; $display("FAIL add_ex: got %b expected 0000000", {mux_a, mux_b, imm_sel}); end
        step();
        checks++; if ({wb_sel, mem_we, reg_we} !== 4'b0000) begin errors++; $display("FAIL add_mem: got %b expected 0000", {wb_sel, mem_we, reg_we}); end
        step();
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL add_reg_we: got %b expected 1", reg_we); end
        step();
        checks++; if ({reg_we, mem_we, load_en} !== 3'b000) begin errors++; $display("FAIL add_after: got %b expected 000", {reg_we, mem_we, load_en}); end
    endtask

    task automatic test_store();
        instr = SW; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++; if ({imm_sel, mux_b} !== 6'b000101) begin errors++; $display("FAIL sw_ex: got %b expected 000101", {imm_sel, mux_b}); end
        step();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_mem_we: got %b expected 1", mem_we); end
        step();
        checks++; if ({mem_we, reg_we} !== 2'b00) begin errors++; $display("FAIL sw_wb: got %b expected 00", {mem_we, reg_we}); end
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL sw_reg_we_late: got %b expected 0", reg_we); end
    endtask

    task automatic test_branch_flush();
        instr = BEQ; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0; br_taken = 1'b1;
        checks++; if ({mux_a, imm_sel, pc_sel} !== 7'b1010000) begin errors++; $display("FAIL beq_ex: got %b expected 1010000", {mux_a, imm_sel, pc_sel}); end
        step();
        br_taken = 1'b0;
        checks++; if (pc_sel !== 1'b1) begin errors++; $display("FAIL beq_pc_sel: got %b expected 1", pc_sel); end
        instr = ADDI; instr_valid = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", instr_ready); end
        step();
        checks++; if ({pc_sel, mux_b, imm_sel} !== 7'b0) begin errors++; $display("FAIL addi_squash_ex: got %b expected 0000000", {pc_sel, mux_b, imm_sel}); end
        instr = ADD;
        step();
        instr_valid = 1'b0;
        checks++; if ({reg_we, pc_sel} !== 2'b00) begin errors++; $display("FAIL flush_reg_we_e4: got %b expected 00", {reg_we, pc_sel}); end
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL addi_reg_we: got %b expected 0", reg_we); end
        step();
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL add_after_flush_reg_we: got %b expected 1", reg_we); end
    endtask

    task automatic test_load_use();
        instr = LW; instr_valid = 1'b1;
        step();
        instr = ADD6;
        #1;
`ifdef CTRL_PIPELINE_HAZARD_EN
        checks++; if ({hazard_stall, instr_ready} !== 2'b10) begin errors++; $display("FAIL hz_raise: got %b expected 10", {hazard_stall, instr_ready}); end
        step();
        checks++; if ({load_en, wb_sel} !== 3'b101) begin errors++; $display("FAIL lw_mem: got %b expected 101", {load_en, wb_sel}); end
        checks++; if ({hazard_stall, instr_ready} !== 2'b01) begin errors++; $display("FAIL hz_drop: got %b expected 01", {hazard_stall, instr_ready}); end
        step();
        instr_valid = 1'b0;
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL lw_reg_we: got %b expected 1", reg_we); end
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL hz_bubble_reg_we: got %b expected 0", reg_we); end
        step();
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL add6_reg_we: got %b expected 1", reg_we); end
`else
        checks++; if ({hazard_stall, instr_ready} !== 2'b01) begin errors++; $display("FAIL no_hz: got %b expected 01", {hazard_stall, instr_ready}); end
        step();
        instr_valid = 1'b0;
        checks++; if ({load_en, wb_sel} !== 3'b101) begin errors++; $display("FAIL lw_mem: got %b expected 101", {load_en, wb_sel}); end
        step();
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL lw_reg_we: got %b expected 1", reg_we); end
        step();
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL add6_reg_we: got %b expected 1", reg_we); end
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL add6_after: got %b expected 0", reg_we); end
`endif
    endtask

    task automatic test_stall();
        instr = SW; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0; stall = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", instr_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({mem_we, instr_ready} !== 2'b00) begin errors++; $display("FAIL stall_hold[%0d]: got %b expected 00", i, {mem_we, instr_ready}); end
        end
        stall = 1'b0;
        step();
        checks++; if ({mem_we, instr_ready} !== 2'b11) begin errors++; $display("FAIL stall_mem_we: got %b expected 11", {mem_we, instr_ready}); end
        step();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL stall_mem_we_once: got %b expected 0", mem_we); end
    endtask

    task automatic test_illegal_reset();
        instr = BAD; instr_valid = 1'b1;
        step();
        instr = LW;
        checks++; if ({illegal, mux_b, imm_sel, mux_a} !== 8'b10000000) begin errors++; $display("FAIL illegal_ex: got %b expected 10000000", {illegal, mux_b, imm_sel, mux_a}); end
        step();
        instr_valid = 1'b0;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %b expected 0", illegal); end
        step();
        checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL lw_inflight: got %b expected 1", load_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({load_en, reg_we, wb_sel, instr_ready} !== 5'b0) begin errors++; $display("FAIL async_reset: got %b expected 00000", {load_en, reg_we, wb_sel, instr_ready}); end
        step();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({load_en, reg_we} !== 2'b00) begin errors++; $display("FAIL post_reset_quiet[%0d]: got %b expected 00", i, {load_en, reg_we}); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_store();
        test_branch_flush();
        test_load_use();
        test_stall();
        test_illegal_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
Parametrised RV32I control unit and control-signal pipeline. It decodes each accepted instruction once into a control bundle and carries that bundle through EX, MEM and WB delay stages. Bubbles are inserted on invalid input, on illegal opcodes, and on flush after a taken branch or jump. The block sits between fetch/instruction memory and the datapath: immediate generator, ALU operand muxes, data memory and register file.

Parameters:
MEM_DEPTH, 2, cycles from the acceptance edge until mem_we, load_en and wb_sel are presented; range 2..4.
WB_DEPTH, 3, cycles from the acceptance edge until reg_we is presented; must be greater than MEM_DEPTH; maximum 6.
FLUSH_SLOTS, 1, number of younger instructions squashed after a redirect; range 0..3.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
instr  in  32  instruction word.
instr_valid  in  1  instr is valid this cycle.
instr_ready  out  1  block accepts instr this cycle.
stall  in  1  datapath freeze; all stages hold.
br_taken  in  1  branch comparator result for the EX-stage instruction.
imm_sel  out  5  EX: one-hot immediate type {UJ,SB,U,S,I}.
mux_a  out  1  EX: 1 selects PC, 0 selects rs1.
mux_b  out  1  EX: 1 selects imm, 0 selects rs2.
alu_unsigned  out  1  EX: SLTU/SLTIU/SRL/SRLI class.
br_unsigned  out  1  EX: instr[13] of a branch, else 0.
pc_sel  out  1  redirect pulse, one cycle after a taken EX branch, JAL or JALR.
mem_we  out  1  MEM-stage store enable.
load_en  out  1  MEM-stage load enable.
wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
reg_we  out  1  WB-stage register write enable.
illegal  out  1  one-cycle pulse when an illegal opcode reaches EX.
hazard_stall  out  1  load-use interlock active (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): all outputs 0; instr_ready 0; every stage register cleared to a bubble; flush counter 0. Outputs return to 0 immediately on reset assertion, without waiting for a clock edge. After release, instr_ready = ~stall (subject to the hazard rule when that feature is enabled).
- Acceptance: an instruction is accepted on a rising edge where instr_valid & instr_ready.
  - If not accepted, a bubble enters EX: all enables and outputs 0.
- Decode is on instr[6:0]:
  - I-type: 0000011, 0010011, 1100111.
  - S: 0100011. U: 0110111, 0010111. SB: 1100011. UJ: 1101111. R: 0110011.
  - Any other opcode: bubble, and illegal=1 in EX.
- mux_a=1 for AUIPC, JAL and branches.
- mux_b=0 only for R-type.
- reg_we=0 for S and SB.
- mem_we only for S. load_en only for opcode 0000011.
- Latency:
  - EX outputs appear 1 cycle after acceptance.
  - mem_we, load_en and wb_sel appear MEM_DEPTH cycles after acceptance.
  - reg_we appears WB_DEPTH cycles after acceptance.
  - Each is valid for exactly one cycle per instruction unless stalled.
- Redirect:
  - Condition: EX holds (SB and br_taken) or JAL or JALR, and stall=0.
  - On the next edge: pc_sel=1 for one cycle and the flush counter loads FLUSH_SLOTS.
  - While the counter is nonzero, each edge turns the incoming instruction into a bubble (it is consumed) and decrements the counter.
  - br_taken is ignored for non-branch EX contents.
- Stall: when stall=1, all stage registers, the flush counter and pc_sel hold; instr_ready=0.
  - Stall has priority over redirect and flush.
  - A redirect condition present during a stall is evaluated on the first unstalled edge.
- Simultaneous events:
  - A redirect arriving while the flush counter is nonzero reloads the counter to FLUSH_SLOTS.
  - The redirecting instruction itself is never squashed.
- FLUSH_SLOTS=0: pc_sel still pulses; no instructions are squashed.

Optional Feature:
CTRL_PIPELINE_HAZARD_EN
- Defined:
  - Interlock condition: EX holds a load with rd≠0, and the offered instr reads that rd. rs1 is checked for every format except U and UJ; rs2 is checked only for R, S and SB.
  - When the condition holds: hazard_stall=1 and instr_ready=0 for exactly one cycle, and a bubble enters EX.
  - The offered instruction must be held by fetch and is accepted on the following cycle.
  - No interlock is raised while the flush counter is nonzero.
- Undefined: hazard_stall is tied 0 and instr_ready = ~stall & rst_n.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) accepted, defaults → EX: mux_a=0, mux_b=0, imm_sel=0; cycle 2: wb_sel=00, mem_we=0; cycle 3: reg_we=1; all enables 0 afterwards.
- SW x2,0(x1) (0x0020A023) → EX: imm_sel=00010, mux_b=1; cycle 2: mem_we=1; reg_we never asserts.
- BEQ (0x00208463) with br_taken=1 in EX, FLUSH_SLOTS=1, followed by ADDI and ADD → pc_sel=1 for one cycle; ADDI squashed (no reg_we); ADD retires normally.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x5 (0x00528333), hazard feature defined → hazard_stall=1 for one cycle; ADD reg_we arrives 4 cycles after its first offer. With the feature undefined: no interlock, 3-cycle latency.
- stall=1 for 3 cycles while a store sits in stage 1 → mem_we deferred by exactly 3 cycles and pulses once; instr_ready=0 throughout the stall.
- Opcode 0x0000007F, then rst_n=0 pulled mid-cycle with a load in flight → illegal=1 one cycle after acceptance with all enables 0; load_en and reg_we drop asynchronously to 0 and stay 0 after reset release.
